// File: rtl/reg_file_wb.sv
// reg_file_wb: 16 x DATA_W general register file with a one-entry write-back
// stage. Reads forward the pending write, so a dependent read issued on the
// edge after a write already sees the new value.
//
// Ports:
//   clk        single clock, rising edge
//   reset      asynchronous active-high reset
//   reg_addr   register address from the decoder stage
//   rd_en      sample an operand read of regs[reg_addr] this edge
//   wr_en      request a write this edge
//   wr_to_acc  1: write goes to ACC_ADDR, 0: write goes to reg_addr
//   wr_data    write data
//   hold       stall: freeze read outputs, drop new write requests
//   rd_data    registered operand read result
//   rd_valid   rd_data was updated at the last edge
//   acc_data   registered accumulator value
//   wb_busy    write-back stage holds an uncommitted write
module reg_file_wb #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NREGS    = 16,
    parameter int unsigned ACC_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        reg_addr,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic              wr_to_acc,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              hold,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] acc_data,
    output logic              wb_busy
);

    localparam int unsigned ADDR_W = 4;
    localparam logic [ADDR_W-1:0] ACC_A = ADDR_W'(ACC_ADDR);

    logic [DATA_W-1:0] regs [NREGS];

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic [DATA_W-1:0] fwd_rd_c;
    logic [DATA_W-1:0] fwd_acc_c;

    // Forwarded values from pre-edge state; the write captured on the same
    // edge is deliberately not visible (read-before-write).
    always_comb begin
        fwd_rd_c  = regs[reg_addr];
        fwd_acc_c = regs[ACC_A];
        if (wb_valid && (wb_addr == reg_addr)) begin
            fwd_rd_c = wb_data;
        end
        if (wb_valid && (wb_addr == ACC_A)) begin
            fwd_acc_c = wb_data;
        end
    end

    // Register array: commit from the write-back stage, never stalled by hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wb_valid) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Write-back stage: capture new requests unless stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else if (wr_en && !hold) begin
            wb_valid <= 1'b1;
            wb_addr  <= wr_to_acc ? ACC_A : reg_addr;
            wb_data  <= wr_data;
        end else begin
            wb_valid <= 1'b0;
        end
    end

    // Operand and accumulator read ports; both freeze under hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            acc_data <= '0;
        end else if (hold) begin
            rd_valid <= 1'b0;
        end else begin
            acc_data <= fwd_acc_c;
            if (rd_en) begin
                rd_data  <= fwd_rd_c;
                rd_valid <= 1'b1;
            end else begin
                rd_valid <= 1'b0;
            end
        end
    end

    assign wb_busy = wb_valid;

endmodule
